// File: rtl/cordic_bus_slave_pkg.sv
// rtl/cordic_bus_slave_pkg.sv - register offsets, control bit indices and FSM states for the CORDIC bus slave
package cordic_bus_pkg;

    localparam logic [7:0] OFF_CONTROL  = 8'h00;
    localparam logic [7:0] OFF_X_IN     = 8'h04;
    localparam logic [7:0] OFF_Y_IN     = 8'h08;
    localparam logic [7:0] OFF_Z_IN     = 8'h0C;
    localparam logic [7:0] OFF_X_RES    = 8'h10;
    localparam logic [7:0] OFF_Y_RES    = 8'h14;
    localparam logic [7:0] OFF_Z_RES    = 8'h18;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h1C;
    localparam logic [7:0] OFF_CYCLES   = 8'h20;

    localparam int c_START   = 0;
    localparam int c_STOP    = 1;
    localparam int c_READY   = 16;
    localparam int c_INP_ERR = 17;
    localparam int c_OV_ERR  = 18;

    localparam int c_STAT_DONE  = 0;
    localparam int c_STAT_ERROR = 1;
    localparam int c_STAT_MASK  = 8;

    // Matches the controller's own reset word so both ends agree before the first write-back.
    localparam logic [31:0] c_CONTROL_RESET = 32'h0001_2F3C;

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_e;

endpackage

// File: rtl/cordic_bus_slave_if.sv
// rtl/cordic_bus_slave_if.sv - host request/response bus between host and CORDIC bus slave
interface cordic_bus_slave_if #(
    parameter int p_WIDTH      = 32,
    parameter int p_ADDR_WIDTH = 6
);
    logic                    reqValid;
    logic                    reqReady;
    logic                    reqWrite;
    logic [p_ADDR_WIDTH-1:0] reqAddr;
    logic [p_WIDTH-1:0]      reqWdata;
    logic                    rspValid;
    logic                    rspReady;
    logic [p_WIDTH-1:0]      rspRdata;
    logic                    rspError;

    modport master (
        output reqValid, reqWrite, reqAddr, reqWdata, rspReady,
        input  reqReady, rspValid, rspRdata, rspError
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqWdata, rspReady,
        output reqReady, rspValid, rspRdata, rspError
    );
endinterface

// File: rtl/cordic_bus_slave_irq_status.sv
// rtl/cordic_bus_slave_irq_status.sv - sticky done/error flags with W1C, set-priority and masked irq
module cordic_irq_status (
    input  logic clk,
    input  logic rst,
    input  logic interrupt,
    input  logic errorCause,
    input  logic statWrite,
    input  logic clrDone,
    input  logic clrError,
    input  logic maskIn,
    output logic done,
    output logic error,
    output logic mask,
    output logic irq
);
    logic doneNext;
    logic errorNext;
    logic maskNext;

    // A pulse arriving alongside a W1C write must not be lost, so set is applied last.
    always_comb begin
        doneNext  = done;
        errorNext = error;
        maskNext  = mask;
        if (statWrite) begin
            if (clrDone)  doneNext  = 1'b0;
            if (clrError) errorNext = 1'b0;
            maskNext = maskIn;
        end
        if (interrupt) begin
            doneNext = 1'b1;
            if (errorCause) errorNext = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done  <= 1'b0;
            error <= 1'b0;
            mask  <= 1'b1;
            irq   <= 1'b0;
        end else begin
            done  <= doneNext;
            error <= errorNext;
            mask  <= maskNext;
            irq   <= (doneNext | errorNext) & maskNext;
        end
    end
endmodule

// File: rtl/cordic_bus_slave.sv
// rtl/cordic_bus_slave.sv - host register front end for the CORDIC controller
// Optional CYCLES busy-time counter at 0x20 enabled by CORDIC_BUS_TIMESTAMP_EN.
module cordic_bus_slave
    import cordic_bus_pkg::*;
#(
    parameter int p_WIDTH      = 32,
    parameter int p_ADDR_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    cordic_bus_slave_if.slave  bus,
    output logic               irq,
    output logic [p_WIDTH-1:0] xInput,
    output logic [p_WIDTH-1:0] yInput,
    output logic [p_WIDTH-1:0] zInput,
    output logic [31:0]        controlRegisterInput,
    input  logic [31:0]        controlRegisterOutput,
    input  logic               controlRegisterWriteEnable,
    input  logic [p_WIDTH-1:0] xResult,
    input  logic [p_WIDTH-1:0] yResult,
    input  logic [p_WIDTH-1:0] zResult,
    input  logic               interrupt
);
    state_e             state;
    logic [31:0]        shadow;
    logic [p_WIDTH-1:0] xReg;
    logic [p_WIDTH-1:0] yReg;
    logic [p_WIDTH-1:0] zReg;
    logic               rspValidQ;
    logic               rspErrorQ;
    logic [p_WIDTH-1:0] rspRdataQ;

    logic               busy;
    logic               accept;
    logic               aligned;
    logic [7:0]         offset;
    logic               mapped;
    logic               writeReject;
    logic               respError;
    logic [p_WIDTH-1:0] readData;
    logic               statWrite;
    logic               statDone;
    logic               statError;
    logic               statMask;

`ifdef CORDIC_BUS_TIMESTAMP_EN
    logic [p_WIDTH-1:0] cycleCount;
    logic               startSeen;
`endif

    assign busy    = !controlRegisterOutput[c_READY];
    assign offset  = 8'(bus.reqAddr);
    assign aligned = (bus.reqAddr[1:0] == 2'b00);

    // Write-back cycles block the bus so the shadow never sees two writers at once.
    assign bus.reqReady = (state == S_IDLE) && !controlRegisterWriteEnable;
    assign accept       = bus.reqValid && bus.reqReady;

    assign bus.rspValid = rspValidQ;
    assign bus.rspError = rspErrorQ;
    assign bus.rspRdata = rspRdataQ;

    assign controlRegisterInput = shadow;
    assign xInput = xReg;
    assign yInput = yReg;
    assign zInput = zReg;

    always_comb begin
        mapped   = 1'b1;
        readData = '0;
        case (offset)
            OFF_CONTROL:  readData = p_WIDTH'(shadow);
            OFF_X_IN:     readData = xReg;
            OFF_Y_IN:     readData = yReg;
            OFF_Z_IN:     readData = zReg;
            OFF_X_RES:    readData = xResult;
            OFF_Y_RES:    readData = yResult;
            OFF_Z_RES:    readData = zResult;
            OFF_IRQ_STAT: readData = p_WIDTH'({23'b0, statMask, 6'b0, statError, statDone});
`ifdef CORDIC_BUS_TIMESTAMP_EN
            OFF_CYCLES:   readData = cycleCount;
`endif
            default:      mapped = 1'b0;
        endcase
        if (!aligned) mapped = 1'b0;
    end

    // Operands are frozen while the controller is iterating on them.
    assign writeReject = bus.reqWrite && busy &&
                         (offset == OFF_X_IN || offset == OFF_Y_IN || offset == OFF_Z_IN);
    assign respError   = !mapped || writeReject;
    assign statWrite   = accept && bus.reqWrite && mapped && (offset == OFF_IRQ_STAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rspValidQ <= 1'b0;
            rspErrorQ <= 1'b0;
            rspRdataQ <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_RESP;
                        rspValidQ <= 1'b1;
                        rspErrorQ <= respError;
                        rspRdataQ <= (bus.reqWrite || respError) ? '0 : readData;
                    end
                end
                S_RESP: begin
                    if (bus.rspReady) begin
                        state     <= S_IDLE;
                        rspValidQ <= 1'b0;
                        rspErrorQ <= 1'b0;
                        rspRdataQ <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= c_CONTROL_RESET;
            xReg   <= '0;
            yReg   <= '0;
            zReg   <= '0;
        end else if (controlRegisterWriteEnable) begin
            shadow <= controlRegisterOutput;
        end else if (accept && bus.reqWrite && mapped) begin
            case (offset)
                OFF_CONTROL: begin
                    if (busy) shadow[c_STOP] <= bus.reqWdata[c_STOP];
                    else      shadow[15:0]   <= bus.reqWdata[15:0];
                end
                OFF_X_IN: if (!busy) xReg <= bus.reqWdata;
                OFF_Y_IN: if (!busy) yReg <= bus.reqWdata;
                OFF_Z_IN: if (!busy) zReg <= bus.reqWdata;
                default: ;
            endcase
        end
    end

`ifdef CORDIC_BUS_TIMESTAMP_EN
    // The controller acknowledging START clears it in its write-back; that marks the run start.
    assign startSeen = controlRegisterWriteEnable && busy &&
                       shadow[c_START] && !controlRegisterOutput[c_START];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycleCount <= '0;
        end else if (startSeen) begin
            cycleCount <= '0;
        end else if (busy && (cycleCount != '1)) begin
            cycleCount <= cycleCount + 1'b1;
        end
    end
`endif

    cordic_irq_status u_irq_status (
        .clk        (clk),
        .rst        (rst),
        .interrupt  (interrupt),
        .errorCause (controlRegisterOutput[c_INP_ERR] | controlRegisterOutput[c_OV_ERR]),
        .statWrite  (statWrite),
        .clrDone    (bus.reqWdata[c_STAT_DONE]),
        .clrError   (bus.reqWdata[c_STAT_ERROR]),
        .maskIn     (bus.reqWdata[c_STAT_MASK]),
        .done       (statDone),
        .error      (statError),
        .mask       (statMask),
        .irq        (irq)
    );
endmodule

// File: tb/tb_cordic_bus_slave.sv
// tb/tb_cordic_bus_slave.sv - directed vector bench for cordic_bus_slave
module tb_cordic_bus_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        irq;
    logic [31:0] xInput, yInput, zInput;
    logic [31:0] controlRegisterInput;
    logic [31:0] controlRegisterOutput = 32'h0001_2F3C;
    logic        controlRegisterWriteEnable = 1'b0;
    logic [31:0] xResult = 32'h1111_1111;
    logic [31:0] yResult = 32'h2222_2222;
    logic [31:0] zResult = 32'h3333_3333;
    logic        interrupt = 1'b0;

    int checks = 0;
    int errors = 0;

    cordic_bus_slave_if #(.p_WIDTH(32), .p_ADDR_WIDTH(6)) bus ();

    cordic_bus_slave #(.p_WIDTH(32), .p_ADDR_WIDTH(6)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .bus                        (bus),
        .irq                        (irq),
        .xInput                     (xInput),
        .yInput                     (yInput),
        .zInput                     (zInput),
        .controlRegisterInput       (controlRegisterInput),
        .controlRegisterOutput      (controlRegisterOutput),
        .controlRegisterWriteEnable (controlRegisterWriteEnable),
        .xResult                    (xResult),
        .yResult                    (yResult),
        .zResult                    (zResult),
        .interrupt                  (interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [5:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqWrite = wr;
        bus.reqAddr  = addr;
        bus.reqWdata = wd;
        n = 0;
        while (!bus.reqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("req_accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 bus.reqValid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bus.rspValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rsp_timeout", 32'(n), 32'd0);
        rd = bus.rspRdata;
        er = bus.rspError;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        vecs[0]  = '{"ctrl_reset",   1'b0, 6'h00, 32'h0,         32'h0001_2F3C, 1'b0};
        vecs[1]  = '{"stat_reset",   1'b0, 6'h1C, 32'h0,         32'h0000_0100, 1'b0};
        vecs[2]  = '{"xin_reset",    1'b0, 6'h04, 32'h0,         32'h0,         1'b0};
        vecs[3]  = '{"xin_wr",       1'b1, 6'h04, 32'h26DD_3B6A, 32'h0,         1'b0};
        vecs[4]  = '{"xin_rd",       1'b0, 6'h04, 32'h0,         32'h26DD_3B6A, 1'b0};
        vecs[5]  = '{"yin_wr",       1'b1, 6'h08, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[6]  = '{"yin_rd",       1'b0, 6'h08, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[7]  = '{"zin_wr",       1'b1, 6'h0C, 32'h0000_FFFF, 32'h0,         1'b0};
        vecs[8]  = '{"zin_rd",       1'b0, 6'h0C, 32'h0,         32'h0000_FFFF, 1'b0};
        vecs[9]  = '{"xres_rd",      1'b0, 6'h10, 32'h0,         32'h1111_1111, 1'b0};
        vecs[10] = '{"yres_rd",      1'b0, 6'h14, 32'h0,         32'h2222_2222, 1'b0};
        vecs[11] = '{"zres_rd",      1'b0, 6'h18, 32'h0,         32'h3333_3333, 1'b0};
        vecs[12] = '{"unmapped_24",  1'b0, 6'h24, 32'h0,         32'h0,         1'b1};
        vecs[13] = '{"unaligned_05", 1'b0, 6'h05, 32'h0,         32'h0,         1'b1};
        vecs[14] = '{"unaligned_wr", 1'b1, 6'h06, 32'hDEAD_BEEF, 32'h0,         1'b1};
        vecs[15] = '{"xin_keep",     1'b0, 6'h04, 32'h0,         32'h26DD_3B6A, 1'b0};
`ifdef CORDIC_BUS_TIMESTAMP_EN
        vecs[16] = '{"cycles_idle",  1'b0, 6'h20, 32'h0,         32'h0,         1'b0};
`else
        vecs[16] = '{"cycles_unmap", 1'b0, 6'h20, 32'h0,         32'h0,         1'b1};
`endif
        vecs[17] = '{"ctrl_wr",      1'b1, 6'h00, 32'h0000_1F3D, 32'h0,         1'b0};
        vecs[18] = '{"ctrl_rd",      1'b0, 6'h00, 32'h0,         32'h0001_1F3D, 1'b0};

        bus.reqValid = 1'b0;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = '0;
        bus.reqWdata = '0;
        bus.rspReady = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_reqReady", 32'(bus.reqReady), 32'd1);
        check("rst_rspValid", 32'(bus.rspValid), 32'd0);
        check("rst_rspRdata", bus.rspRdata, 32'd0);
        check("rst_rspError", 32'(bus.rspError), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_xInput", xInput, 32'd0);
        check("rst_ctrlIn", controlRegisterInput, 32'h0001_2F3C);
        rst = 1'b1;

        // Reset landing in RESP must drop the response at once.
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = 6'h04;
        @(posedge clk);
        #1 bus.reqValid = 1'b0;
        check("resp_before_rst", 32'(bus.rspValid), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_rspValid", 32'(bus.rspValid), 32'd0);
        check("rst_mid_reqReady", 32'(bus.reqReady), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, er);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].expRd);
            check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].expErr));
        end

        // Controller goes busy.
        @(negedge clk);
        controlRegisterOutput = 32'h0000_0F3C;
        @(negedge clk);
        check("busy_xInput", xInput, 32'h26DD_3B6A);
        check("busy_start", 32'(controlRegisterInput[0]), 32'd1);
        access(1'b1, 6'h08, 32'd5, rd, er);
        check("busy_yin_wr_err", 32'(er), 32'd1);
        access(1'b0, 6'h08, 32'd0, rd, er);
        check("busy_yin_keep", rd, 32'hA5A5_A5A5);
        check("busy_yInput", yInput, 32'hA5A5_A5A5);
        access(1'b1, 6'h00, 32'h2, rd, er);
        check("busy_stop_err", 32'(er), 32'd0);
        access(1'b0, 6'h00, 32'd0, rd, er);
        check("busy_stop_rd", rd, 32'h0001_1F3F);

        // Write-back collides with a pending request.
        @(negedge clk);
        controlRegisterWriteEnable = 1'b1;
        controlRegisterOutput      = 32'h0000_1F3C;
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = 6'h00;
        #1;
        check("wb_reqReady_low", 32'(bus.reqReady), 32'd0);
        @(negedge clk);
        controlRegisterWriteEnable = 1'b0;
        #1;
        check("wb_reqReady_back", 32'(bus.reqReady), 32'd1);
        @(posedge clk);
        #1 bus.reqValid = 1'b0;
        @(negedge clk);
        check("wb_rspValid", 32'(bus.rspValid), 32'd1);
        check("wb_ctrl_rd", bus.rspRdata, 32'h0000_1F3C);
        check("wb_start_clear", 32'(controlRegisterInput[0]), 32'd0);
        controlRegisterOutput = 32'h0001_2F3C;
`ifdef CORDIC_BUS_TIMESTAMP_EN
        access(1'b0, 6'h20, 32'd0, rd, er);
        check("cycles_run", rd, 32'd1);
`endif

        // Interrupt with input-error flag.
        @(negedge clk);
        controlRegisterOutput = 32'h0003_2F3C;
        interrupt = 1'b1;
        @(negedge clk);
        interrupt = 1'b0;
        check("irq_set", 32'(irq), 32'd1);
        access(1'b0, 6'h1C, 32'd0, rd, er);
        check("stat_set", rd, 32'h0000_0103);

        // W1C racing a second pulse: set wins.
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b1;
        bus.reqAddr  = 6'h1C;
        bus.reqWdata = 32'h0000_0103;
        interrupt    = 1'b1;
        @(posedge clk);
        #1;
        bus.reqValid = 1'b0;
        interrupt    = 1'b0;
        @(negedge clk);
        check("race_err", 32'(bus.rspError), 32'd0);
        access(1'b0, 6'h1C, 32'd0, rd, er);
        check("race_stat", rd, 32'h0000_0103);
        check("race_irq", 32'(irq), 32'd1);

        controlRegisterOutput = 32'h0001_2F3C;
        access(1'b1, 6'h1C, 32'h0000_0103, rd, er);
        access(1'b0, 6'h1C, 32'd0, rd, er);
        check("clr_stat", rd, 32'h0000_0100);
        check("clr_irq", 32'(irq), 32'd0);

        // Response must hold while the host stalls.
        @(negedge clk);
        bus.rspReady = 1'b0;
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = 6'h24;
        @(posedge clk);
        #1 bus.reqValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_rspValid", 32'(bus.rspValid), 32'd1);
            check("stall_rspRdata", bus.rspRdata, 32'd0);
            check("stall_rspError", 32'(bus.rspError), 32'd1);
            check("stall_reqReady", 32'(bus.reqReady), 32'd0);
        end
        bus.rspReady = 1'b1;
        @(negedge clk);
        check("stall_release", 32'(bus.rspValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
